// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that shares an N:1 bit mux, one capped-length grant at a time.
// Revision 1.0
`default_nettype none

module rr_mux_arbiter #(
  parameter int N        = 8,
  parameter int SEL      = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   data_in,
  output logic [N-1:0]   grant,
  output logic [SEL-1:0] sel,
  output logic           busy,
  output logic           out,
  output logic           timeout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t         state, state_nx;
  logic [HW-1:0]  hold, hold_nx;
  logic [SEL-1:0] ptr, ptr_nx;
  logic [SEL-1:0] sel_nx;
  logic [N-1:0]   grant_nx;
  logic           busy_nx, out_nx, timeout_nx;

  logic [SEL-1:0] pick;
  logic [SEL-1:0] cand;
  logic           found;
  int             idx;
  logic           limit_hit;

  // Rotating priority search starting at ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      cand = SEL'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign limit_hit = (hold == HW'(MAX_HOLD - 1));

  always_comb begin
    state_nx   = state;
    hold_nx    = hold;
    ptr_nx     = ptr;
    sel_nx     = sel;
    grant_nx   = grant;
    busy_nx    = busy;
    out_nx     = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nx = S_GRANT;
          grant_nx = N'(1) << pick;
          sel_nx   = pick;
          busy_nx  = 1'b1;
          hold_nx  = '0;
        end
      end
      S_GRANT: begin
        out_nx  = data_in[sel];
        hold_nx = hold + HW'(1);
        // A request dropping on the limit edge is a normal release, not a timeout.
        if (!req[sel] || limit_hit) begin
          state_nx   = S_IDLE;
          grant_nx   = '0;
          busy_nx    = 1'b0;
          hold_nx    = '0;
          ptr_nx     = (sel == SEL'(N - 1)) ? '0 : sel + SEL'(1);
          timeout_nx = req[sel];
        end
      end
      default: begin
        state_nx = S_IDLE;
        grant_nx = '0;
        busy_nx  = 1'b0;
        hold_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      hold    <= '0;
      ptr     <= '0;
      sel     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      out     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      hold    <= hold_nx;
      ptr     <= ptr_nx;
      sel     <= sel_nx;
      grant   <= grant_nx;
      busy    <= busy_nx;
      out     <= out_nx;
      timeout <= timeout_nx;
    end
  end

endmodule

`default_nettype wire

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and select sequencer for the N:1 bit multiplexer. Shares the mux among N requesters by granting one at a time. Drives the mux select from the grant and returns the selected data bit as a registered output. Each grant is capped by a hold-time limit so no requester can starve the others.

## Interface

Parameters:
- N, 8, number of requesters / mux inputs (2..2^SEL)
- SEL, 3, select width; N <= 2^SEL
- MAX_HOLD, 4, maximum cycles a grant is held (>= 1)

Ports:
- clk  input  1  clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  request vector, bit i = requester i
- data_in  input  N  mux data inputs, bit i belongs to requester i
- grant  output  N  one-hot grant, all-zero when idle
- sel  output  SEL  mux select = index of granted requester
- busy  output  1  high while a grant is active
- out  output  1  registered mux output
- timeout  output  1  one-cycle pulse when a grant is ended by MAX_HOLD

## Operation

- Reset (async, rst_n low): state IDLE; grant=0, sel=0, busy=0, out=0, timeout=0, hold counter=0, priority pointer ptr=0. Outputs stay at these values while rst_n is low.
- State IDLE:
  - If req==0, the block stays in IDLE.
  - Otherwise it picks the first i with req[i]=1, searching ptr, ptr+1, … N-1, 0, … ptr-1 (wrap modulo N).
  - Next state GRANT: grant=1<<i, sel=i, busy=1, hold=0.
- State GRANT:
  - hold increments each cycle.
  - Release on the first edge where req[sel]==0, or where hold==MAX_HOLD-1 (timeout).
  - On release: state goes to IDLE, grant=0, busy=0, sel keeps its last value, ptr=(sel+1) mod N.
  - timeout=1 for one cycle only if req[sel] was still high at release. If req drops on the same edge the limit is reached, it is a normal release and timeout=0.
- out is registered:
  - out <= data_in[sel] while in GRANT, including the release edge' sampling cycle.
  - out <= 0 in IDLE.
- Requests on inputs other than the granted one have no effect during GRANT. They are only considered at the next IDLE arbitration.
- Bits of sel at or above N are never produced.

## Timing

- Grant latency: a request sampled at edge t while in IDLE gives grant/sel/busy valid after edge t.
- out latency: one cycle behind sel/data_in. First valid out appears after edge t+1.
- Grant duration: at least 1 cycle, at most MAX_HOLD cycles.
- Back-to-back: there is always exactly one IDLE cycle (grant=0) between consecutive grants, even if requests are pending.
- timeout goes high in that IDLE cycle, coincident with grant=0.
- Reset mid-grant: outputs clear immediately. After rst_n releases, arbitration restarts from ptr=0.

## Test plan

1. Reset: rst_n=0 for 3 cycles with req=8'hFF → grant=0, sel=0, busy=0, out=0, timeout=0 throughout. First grant after release is grant=8'h01.
2. Single request: data_in=8'b11001101, req=8'h04 held for 2 cycles then dropped.
   - grant=8'h04, sel=2, busy=1 for 2 cycles; out=1 one cycle after grant.
   - Then grant=0, timeout=0, and next search starts at ptr=3.
3. Full contention: req=8'hFF constant, MAX_HOLD=4.
   - grants 8'h01, 8'h02, … 8'h80, 8'h01 in order, each for exactly 4 cycles.
   - One idle cycle between grants, with timeout=1 in each idle cycle.
4. Round-robin order: grant requester 5, then req=8'b01001000 (requesters 3 and 6) → next grant is sel=6, followed by sel=3.
5. Data tracking: with sel=0 granted and req[0] held, toggle data_in[0] 1→0→1 on successive cycles → out follows with exactly one cycle of lag. out=0 after release.
6. Reset mid-grant: assert rst_n low asynchronously during the 2nd cycle of the grant to requester 4 → outputs clear without waiting for clk. After release, req=8'h30 is granted to sel=4 first (ptr=0).
